// File: rtl/lane_reorder_pkg.sv
// lane_reorder_pkg: shared constants and helpers for the lane reorder stage.
//   MODE_PASS / MODE_REV / MODE_ROT / MODE_SWP : 2-bit permutation selects
//   rot_w(lanes) : width of the rotate-amount field, clog2(lanes) but never 0
package lane_reorder_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;  // out lane i = in lane i
  localparam logic [1:0] MODE_REV  = 2'b01;  // out lane i = in lane LANES-1-i
  localparam logic [1:0] MODE_ROT  = 2'b10;  // out lane i = in lane (i+rot) mod LANES
  localparam logic [1:0] MODE_SWP  = 2'b11;  // lanes 2k and 2k+1 exchanged

  // A 2-lane stage still needs a 1-bit rotate field, so clamp at 1.
  function automatic int rot_w(input int lanes);
    return (lanes <= 2) ? 1 : $clog2(lanes);
  endfunction

endpackage

// File: rtl/lane_permute.sv
// lane_permute: purely combinational lane permutation.
//   data    in  LANES*WIDTH  lane i = data[i*WIDTH +: WIDTH]
//   mode    in  2            MODE_PASS / MODE_REV / MODE_ROT / MODE_SWP
//   rot_amt in  rot_w(LANES) rotate amount, only used by MODE_ROT
//   perm    out LANES*WIDTH  permuted lanes
module lane_permute
  import lane_reorder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic [LANES*WIDTH-1:0]   data,
  input  logic [1:0]               mode,
  input  logic [rot_w(LANES)-1:0]  rot_amt,
  output logic [LANES*WIDTH-1:0]   perm
);

  // Source lane feeding output lane i. The modulo keeps rotate amounts
  // >= LANES in range (possible when LANES is not a power of two), and the
  // pair-swap leaves an unpaired last lane in place for odd LANES.
  function automatic int src_lane(input int i, input logic [1:0] m, input int r);
    case (m)
      MODE_REV: return LANES - 1 - i;
      MODE_ROT: return (i + r) % LANES;
      MODE_SWP: return ((i ^ 1) < LANES) ? (i ^ 1) : i;
      default:  return i;
    endcase
  endfunction

  // Mux per output lane with constant part-selects; exactly one j matches.
  always_comb begin
    perm = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        if (src_lane(i, mode, int'(rot_amt)) == j) begin
          perm[i*WIDTH +: WIDTH] = data[j*WIDTH +: WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/lane_reorder_reg.sv
// lane_reorder_reg: registered lane-reordering stage with a 2-entry skid buffer.
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   in_valid  in   input beat valid
//   in_ready  out  stage can accept a beat (= ~skid_valid)
//   in_data   in   LANES*WIDTH, lane i = bits [i*WIDTH +: WIDTH]
//   mode      in   permutation select, sampled with the beat
//   rot_amt   in   rotate amount for MODE_ROT
//   out_valid out  output beat valid
//   out_ready in   downstream accepts
//   out_data  out  permuted beat
//   out_mode  out  mode out_data was built with
//   beat_cnt  out  accepted input beats, wraps modulo 2^CNT_W
//
// Handshake: a beat moves on an interface in any cycle where valid and ready
// are both high at the rising edge. A source holds valid and its payload
// stable until that happens; valid never depends on ready. The output
// register loads whenever it is empty or draining, preferring the skid entry
// over a fresh beat so order is preserved. A beat accepted while the output
// is stalled parks in the skid entry, which drops in_ready for the next cycle.
module lane_reorder_reg
  import lane_reorder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   in_data,
  input  logic [1:0]               mode,
  input  logic [rot_w(LANES)-1:0]  rot_amt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   out_data,
  output logic [1:0]               out_mode,
  output logic [CNT_W-1:0]         beat_cnt
);

  logic [LANES*WIDTH-1:0] perm_data;
  logic                   skid_valid;
  logic [LANES*WIDTH-1:0] skid_data;
  logic [1:0]             skid_mode;
  logic                   accept;
  logic                   out_load;

  // Permute on the way in so both storage entries hold final lane order.
  lane_permute #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_permute (
    .data    (in_data),
    .mode    (mode),
    .rot_amt (rot_amt),
    .perm    (perm_data)
  );

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign out_load = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_mode   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_mode  <= '0;
      beat_cnt   <= '0;
    end else begin
      if (accept) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end

      if (out_load) begin
        // skid_valid implies no accept this cycle (in_ready is low).
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_data   <= skid_data;
          out_mode   <= skid_mode;
          skid_valid <= 1'b0;
        end else if (accept) begin
          out_valid <= 1'b1;
          out_data  <= perm_data;
          out_mode  <= mode;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        // Output stalled: park the beat; out_data/out_mode stay untouched.
        skid_valid <= 1'b1;
        skid_data  <= perm_data;
        skid_mode  <= mode;
      end
    end
  end

endmodule

// File: doc/lane_reorder_reg.md
Name: lane_reorder_reg

Overview:
- Parametrised registered lane-reordering stage: accepts LANES lanes of WIDTH bits each and permutes them per a per-beat mode.
  - Modes: pass, reverse, rotate, pair-swap.
- Generalises the 2-lane order/swap output register to N lanes and four modes.
- Adds a valid/ready handshake with a 2-entry skid buffer, and a clean asynchronous reset.
- Sits between datapath stages that need lane-order normalisation (endian/lane swap) without throughput loss.

Parameters:
- WIDTH, 8, bits per lane (>=1)
- LANES, 4, number of lanes (>=2)
- CNT_W, 16, width of the accepted-beat counter

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_data  in  LANES*WIDTH  lane i = bits [i*WIDTH +: WIDTH]
- mode  in  2  permutation select, sampled with the beat
- rot_amt  in  clog2(LANES) (min 1)  rotate amount, used in mode ROT only
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  LANES*WIDTH  permuted beat
- out_mode  out  2  mode the current out_data was built with
- beat_cnt  out  CNT_W  count of accepted input beats, wraps modulo 2^CNT_W

Behaviour:
- Reset:
  - Asserting reset_n=0 immediately clears out_valid, out_data, out_mode, skid valid, skid data and beat_cnt to 0, regardless of clk.
  - Reset has priority over every other update; there is no later same-cycle override.
  - in_ready = ~skid_valid, so it reads 1 during reset. Beats presented while reset_n=0 are discarded and not counted.
- Permutation, applied at accept time (out lane i):
  - PASS 2'b00: in lane i.
  - REV 2'b01: in lane LANES-1-i.
  - ROT 2'b10: in lane (i+rot_amt) mod LANES. Any rot_amt >= LANES is reduced modulo LANES, never X.
  - SWP 2'b11: lanes 2k and 2k+1 exchanged. If LANES is odd, the last lane passes through.
- Handshake:
  - Accept = in_valid & in_ready. Transfer = out_valid & out_ready.
  - Latency: an accepted beat appears on out_data the next cycle if the output register is free or draining.
  - Output register loads when !out_valid or out_ready. Its source is the skid entry if skid_valid, else the accepted beat.
  - If an accept occurs while the output register is held (out_valid & !out_ready), the beat goes to the skid buffer; skid_valid is set, so in_ready drops the following cycle.
  - When the skid is valid and the output drains, the skid moves to the output and skid_valid clears.
  - Beat order is strictly preserved. No beat is ever dropped or duplicated.
  - out_data and out_mode are stable while out_valid & !out_ready.
  - Full throughput with out_ready held high: one beat per cycle, with in_ready never deasserting.
- beat_cnt increments by 1 on each accept and wraps from all-ones to 0.
- mode and rot_amt are don't-care when in_valid=0.

Decomposition:
- Package lane_reorder_pkg:
  - Mode constants MODE_PASS, MODE_REV, MODE_ROT, MODE_SWP (2 bits).
  - Function computing the rotate-index width, clog2 with a minimum of 1.
- Sub-module lane_permute: purely combinational, parameters WIDTH and LANES; inputs data, mode, rot_amt; output permuted data.
  - Instantiated once on the input path, so the skid and output registers hold already-permuted data.
- Top-level holds the output register, skid register and counter.

Test Plan (WIDTH=8, LANES=4, in_data=0x44332211, out_ready=1):
- Mode sweep: PASS, REV, ROT rot_amt=1, SWP on consecutive cycles -> out_data is 0x44332211, 0x11223344, 0x11443322, 0x33441122 on successive cycles, one cycle after each accept; out_mode tracks 0,1,2,3; beat_cnt=4.
- Rotate wrap: ROT with rot_amt=0 and rot_amt=3 -> 0x44332211 and 0x33221144.
- Backpressure:
  - Hold out_ready=0 and send A=0x000000AA then B=0x000000BB in PASS -> out_data=A held stable; in_ready=0 after B is accepted; C is not accepted.
  - Release out_ready -> A, then B, then C in order, each exactly once.
- Streaming: 100 random beats with random modes, out_ready toggled randomly -> scoreboard matches the reference permutation in order; beat_cnt=100.
- Async reset mid-stream:
  - Drop reset_n between clock edges with both output and skid valid -> out_valid=0, out_data=0, beat_cnt=0 immediately; in_ready=1.
  - After release, the first new beat passes normally.
- Counter wrap: CNT_W=4, 17 accepts -> beat_cnt=1.
